fpu_store_word_serializer: RTL and testbench

- Store-side stage directly downstream of the FP80→FP32 converter (and its FP64/FP80/int siblings).
- Takes one converted result on a start pulse (typically the converter's done) and writes it to memory as successive 16-bit little-endian words over a req/ack bus.
- Drives incrementing addresses, ack timeout, and a single completion pulse back to the FPU control sequencer.

---
 rtl/fpu_store_pkg.sv | 59 +++++
 rtl/fpu_store_word_serializer.sv | 130 +++++++++++++
 tb/tb_fpu_store_word_serializer.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fpu_store_pkg.sv
// Shared definitions for the FPU store serializer and the load-side deserializer:
// operand formats, word counts and the transfer state encoding.
package fpu_store_pkg;

    localparam int unsigned WORD_W    = 16;
    localparam int unsigned DATA_W    = 80;
    localparam int unsigned MAX_WORDS = 5;
    localparam int unsigned IDX_W     = 3;

    typedef enum logic [1:0] {
        FMT_FP32  = 2'b00,
        FMT_FP64  = 2'b01,
        FMT_FP80  = 2'b10,
        FMT_INT16 = 2'b11
    } fmt_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        GAP  = 2'b10
    } state_e;

    // Operand captured at start; held for the whole transfer.
    typedef struct packed {
        fmt_e                fmt;
        logic [DATA_W-1:0]   data;
    } operand_t;

    // Number of 16-bit words occupied by each format.
    function automatic logic [IDX_W-1:0] word_count(input fmt_e f);
        logic [IDX_W-1:0] n;
        n = IDX_W'(2);
        case (f)
            FMT_FP32:  n = IDX_W'(2);
            FMT_FP64:  n = IDX_W'(4);
            FMT_FP80:  n = IDX_W'(5);
            FMT_INT16: n = IDX_W'(1);
            default:   n = IDX_W'(2);
        endcase
        return n;
    endfunction

    // Little-endian word k of a right-justified operand.
    function automatic logic [WORD_W-1:0] word_of(input logic [DATA_W-1:0] d,
                                                  input logic [IDX_W-1:0]  k);
        logic [WORD_W-1:0] w;
        w = '0;
        case (k)
            IDX_W'(0): w = d[15:0];
            IDX_W'(1): w = d[31:16];
            IDX_W'(2): w = d[47:32];
            IDX_W'(3): w = d[63:48];
            IDX_W'(4): w = d[79:64];
            default:   w = '0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/fpu_store_word_serializer.sv
// Writes one converted FPU result to memory as successive 16-bit little-endian
// words over a req/ack bus, with ack timeout and a single completion pulse.
module fpu_store_word_serializer
    import fpu_store_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 20,
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [1:0]            fmt,
    input  logic [DATA_W-1:0]     data_in,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    output logic                  busy,
    output logic                  done,
    output logic                  bus_error,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WORD_W-1:0]     mem_data,
    output logic                  mem_wr_req,
    input  logic                  mem_ack
);

    localparam int unsigned TO_W = (ACK_TIMEOUT < 1) ? 1 : $clog2(ACK_TIMEOUT + 1);

    state_e                state_q;
    operand_t              op_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [IDX_W-1:0]      idx_q;
    logic [IDX_W-1:0]      last_q;
    logic [TO_W-1:0]       tmo_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  berr_q;
    logic                  req_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [WORD_W-1:0]     wdata_q;

    logic [TO_W-1:0]       tmo_d;
    logic                  tmo_expired;
    logic [ADDR_WIDTH-1:0] addr_d;

    // Wait-counter increment and expiry; a zero timeout never expires.
    always_comb begin
        tmo_d       = tmo_q + TO_W'(1);
        tmo_expired = (ACK_TIMEOUT != 0) && (tmo_d == TO_W'(ACK_TIMEOUT));
        addr_d      = base_q + ADDR_WIDTH'({idx_q, 1'b0});
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= '0;
            base_q  <= '0;
            idx_q   <= '0;
            last_q  <= '0;
            tmo_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            berr_q  <= 1'b0;
            req_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        op_q.fmt  <= fmt_e'(fmt);
                        op_q.data <= data_in;
                        base_q    <= base_addr;
                        last_q    <= word_count(fmt_e'(fmt)) - IDX_W'(1);
                        idx_q     <= '0;
                        tmo_q     <= '0;
                        berr_q    <= 1'b0;
                        addr_q    <= base_addr;
                        wdata_q   <= data_in[WORD_W-1:0];
                        req_q     <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= REQ;
                    end
                end
                REQ: begin
                    // Ack wins over a simultaneous timeout expiry.
                    if (mem_ack) begin
                        req_q <= 1'b0;
                        tmo_q <= '0;
                        if (idx_q == last_q) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            idx_q   <= idx_q + IDX_W'(1);
                            state_q <= GAP;
                        end
                    end else if (tmo_expired) begin
                        req_q   <= 1'b0;
                        tmo_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        berr_q  <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        tmo_q <= tmo_d;
                    end
                end
                GAP: begin
                    addr_q  <= addr_d;
                    wdata_q <= word_of(op_q.data, idx_q);
                    tmo_q   <= '0;
                    req_q   <= 1'b1;
                    state_q <= REQ;
                end
                default: begin
                    req_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign bus_error  = berr_q;
    assign mem_addr   = addr_q;
    assign mem_data   = wdata_q;
    assign mem_wr_req = req_q;

endmodule

// File: tb/tb_fpu_store_word_serializer.sv
// Self-checking bench: directed table, corner-case sequences and randomized
// transfers checked against a word-list reference model.
module tb_fpu_store_word_serializer;

    localparam int unsigned AW  = 20;
    localparam int unsigned TMO = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [1:0]    fmt;
    logic [79:0]   data_in;
    logic [AW-1:0] base_addr;
    logic          busy;
    logic          done;
    logic          bus_error;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_data;
    logic          mem_wr_req;
    logic          mem_ack;

    fpu_store_word_serializer #(.ADDR_WIDTH(AW), .ACK_TIMEOUT(TMO)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .fmt       (fmt),
        .data_in   (data_in),
        .base_addr (base_addr),
        .busy      (busy),
        .done      (done),
        .bus_error (bus_error),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_wr_req(mem_wr_req),
        .mem_ack   (mem_ack)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int c0     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory responder / monitor state
    int           ack_wait   = 0;
    bit           never_ack  = 1'b0;
    int           req_age    = 0;
    int           req_cycles = 0;
    int           done_cnt   = 0;
    int           done_at    = 0;
    logic [35:0]  wr_q[$];
    logic [35:0]  exp_q[$];

    typedef struct {
        logic [1:0]    f;
        logic [79:0]   d;
        logic [AW-1:0] b;
        int            w;
        int            exp_done;
        int            exp_n;
        logic [AW-1:0] a0;
        logic [15:0]   d0;
        logic [AW-1:0] al;
        logic [15:0]   dl;
    } vec_t;

    vec_t tbl[5];

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int model_words(input logic [1:0] f);
        case (f)
            2'b00:   return 2;
            2'b01:   return 4;
            2'b10:   return 5;
            default: return 1;
        endcase
    endfunction

    task automatic build_exp(input logic [1:0] f, input logic [79:0] d, input logic [AW-1:0] b);
        logic [79:0]   sh;
        logic [AW-1:0] a;
        exp_q.delete();
        for (int k = 0; k < model_words(f); k++) begin
            sh = d >> (16 * k);
            a  = AW'(b + AW'(2 * k));
            exp_q.push_back({a, sh[15:0]});
        end
    endtask

    // Responder: ack after ack_wait extra cycles; random ack noise while req is low.
    always @(negedge clk) begin
        logic a;
        if (mem_wr_req) begin
            if (wr_q.size() < exp_q.size()) begin
                chk("req_addr_data", {mem_addr, mem_data}, exp_q[wr_q.size()]);
            end else begin
                checks++;
                errors++;
                $display("FAIL extra_req actual=%0h expected=no_request", {mem_addr, mem_data});
            end
            a = !never_ack && (req_age >= ack_wait);
            req_age++;
            req_cycles++;
            if (a) wr_q.push_back({mem_addr, mem_data});
        end else begin
            req_age = 0;
            a = 1'($urandom_range(0, 1));
        end
        mem_ack = a;
        if (done) begin
            done_cnt++;
            done_at = cyc;
            chk("done_without_req", mem_wr_req, 1'b0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_xfer(input logic [1:0] f, input logic [79:0] d,
                              input logic [AW-1:0] b, input int w, input bit nev);
        tick();
        ack_wait   = w;
        never_ack  = nev;
        wr_q.delete();
        done_cnt   = 0;
        req_cycles = 0;
        build_exp(f, d, b);
        fmt       = f;
        data_in   = d;
        base_addr = b;
        start     = 1'b1;
        c0        = cyc;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_done(output int dc);
        for (int i = 0; i < 300; i++) begin
            if (done_cnt > 0) break;
            tick();
        end
        if (done_cnt == 0) begin
            checks++;
            errors++;
            $display("FAIL done_wait actual=no_done expected=done_within_300_cycles");
            dc = -1;
        end else begin
            dc = done_at - c0;
        end
    endtask

    task automatic check_writes(input string nm);
        chk({nm, "_count"}, wr_q.size(), exp_q.size());
        for (int i = 0; i < wr_q.size() && i < exp_q.size(); i++)
            chk($sformatf("%s_w%0d", nm, i), wr_q[i], exp_q[i]);
    endtask

    task automatic check_reset_outputs(input string nm);
        chk({nm, "_busy"}, busy, 1'b0);
        chk({nm, "_done"}, done, 1'b0);
        chk({nm, "_bus_error"}, bus_error, 1'b0);
        chk({nm, "_req"}, mem_wr_req, 1'b0);
        chk({nm, "_addr"}, mem_addr, '0);
        chk({nm, "_data"}, mem_data, '0);
    endtask

    task automatic run_vec(input string nm, input vec_t v);
        int dc;
        start_xfer(v.f, v.d, v.b, v.w, 1'b0);
        wait_done(dc);
        chk({nm, "_done_cycle"}, dc, v.exp_done);
        chk({nm, "_nwrites"}, wr_q.size(), v.exp_n);
        if (wr_q.size() > 0) begin
            chk({nm, "_first"}, wr_q[0], {v.a0, v.d0});
            chk({nm, "_last"}, wr_q[wr_q.size() - 1], {v.al, v.dl});
        end
        chk({nm, "_bus_error"}, bus_error, 1'b0);
        chk({nm, "_busy_after"}, busy, 1'b0);
        check_writes({nm, "_model"});
    endtask

    initial begin
        int dc;
        int n;
        logic [1:0]    rf;
        logic [79:0]   rd;
        logic [AW-1:0] rb;
        int            rw;

        tbl[0] = '{2'b00, 80'h3FC00000, 20'h01000, 0, 4, 2,
                   20'h01000, 16'h0000, 20'h01002, 16'h3FC0};
        tbl[1] = '{2'b10, 80'h4000_C000000000000000, 20'h00200, 3, 25, 5,
                   20'h00200, 16'h0000, 20'h00208, 16'h4000};
        tbl[2] = '{2'b01, 80'h0123456789ABCDEF, 20'hFFFFC, 0, 8, 4,
                   20'hFFFFC, 16'hCDEF, 20'h00002, 16'h0123};
        tbl[3] = '{2'b11, 80'hAAAA_BBBB_CCCC_DDDD_1234, 20'h12345, 1, 3, 1,
                   20'h12345, 16'h1234, 20'h12345, 16'h1234};
        tbl[4] = '{2'b10, 80'h1111_2222_3333_4444_5555, 20'hFFFF8, 1, 15, 5,
                   20'hFFFF8, 16'h5555, 20'h00000, 16'h1111};

        reset     = 1'b1;
        start     = 1'b0;
        fmt       = 2'b00;
        data_in   = '0;
        base_addr = '0;
        mem_ack   = 1'b0;
        repeat (3) tick();
        check_reset_outputs("reset");
        reset = 1'b0;

        for (int i = 0; i < 5; i++) run_vec($sformatf("vec%0d", i), tbl[i]);

        // Ack never arrives: abort after TMO request cycles, then recover.
        start_xfer(2'b00, 80'h3FC00000, 20'h01000, 0, 1'b1);
        wait_done(dc);
        chk("tmo_done_cycle", dc, 1 + TMO);
        chk("tmo_bus_error", bus_error, 1'b1);
        chk("tmo_req_cycles", req_cycles, TMO);
        chk("tmo_nwrites", wr_q.size(), 0);
        chk("tmo_busy", busy, 1'b0);
        start_xfer(2'b00, 80'h3FC00000, 20'h01000, 0, 1'b0);
        chk("tmo_clear_bus_error", bus_error, 1'b0);
        wait_done(dc);
        chk("tmo_recover_done_cycle", dc, 4);
        check_writes("tmo_recover");

        // A second start while busy must not disturb the transfer.
        start_xfer(2'b00, 80'h3FC00000, 20'h01000, 2, 1'b0);
        tick();
        fmt       = 2'b10;
        data_in   = 80'hDEAD_BEEF_CAFE_F00D_5A5A;
        base_addr = 20'h55550;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        wait_done(dc);
        chk("busy_start_done_cycle", dc, 8);
        check_writes("busy_start");
        repeat (15) tick();
        chk("busy_start_single_done", done_cnt, 1);
        chk("busy_start_idle", busy, 1'b0);

        // Reset while word 2 of an FP80 transfer is on the bus.
        start_xfer(2'b10, 80'h4000_C000000000000000, 20'h00200, 0, 1'b0);
        for (int i = 0; i < 20 && (cyc - c0) < 5; i++) tick();
        chk("rst_mid_req", mem_wr_req, 1'b1);
        chk("rst_mid_addr", mem_addr, 20'h00204);
        reset = 1'b1;
        tick();
        check_reset_outputs("rst_mid");
        reset = 1'b0;
        repeat (10) tick();
        chk("rst_mid_no_done", done_cnt, 0);
        run_vec("after_reset", tbl[0]);

        // Randomized transfers against the word-list model.
        for (int i = 0; i < 40; i++) begin
            rf = 2'($urandom_range(0, 3));
            rd = 80'({$urandom, $urandom, $urandom});
            rb = AW'($urandom);
            rw = int'($urandom_range(0, 3));
            n  = model_words(rf);
            start_xfer(rf, rd, rb, rw, 1'b0);
            wait_done(dc);
            chk($sformatf("rand%0d_done_cycle", i), dc, 2 * n + n * rw);
            chk($sformatf("rand%0d_bus_error", i), bus_error, 1'b0);
            check_writes($sformatf("rand%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
